ofmap_writer_layer_3: RTL and testbench
=======================================

OFMAP_WRITER_LAYER_3 -- requirements
Module: ofmap_writer_layer_3

Interface
REQ-001 Parameter DATA_W, default 16, width of one output activation word.
REQ-002 Parameter Y_MAX, default 29, last y index (inner loop); frame height is Y_MAX+1.
REQ-003 Parameter X_MAX, default 29, last x index (middle loop); frame width is X_MAX+1.
REQ-004 Parameter CH_MAX, default 63, last output-channel index (outer loop).
REQ-005 Parameter ADDR_W, default 16, write-address width; must satisfy (CH_MAX+1)(X_MAX+1)(Y_MAX+1) <= 2^ADDR_W.
REQ-006 clk  input  1  clock; all state changes on the rising edge.
REQ-007 rst  input  1  asynchronous reset, active-low.
REQ-008 start  input  1  one-cycle pulse that begins a frame write; honoured only in IDLE.
REQ-009 in_valid  input  1  the PE pipeline presents a result word.
REQ-010 in_data  input  DATA_W  result word.
REQ-011 in_ready  output  1  the block accepts in_data this cycle.
REQ-012 mem_ready  input  1  the output buffer accepts the pending write this cycle.
REQ-013 wr_en  output  1  a write is pending on wr_addr/wr_data.
REQ-014 wr_addr  output  ADDR_W  output-buffer word address.
REQ-015 wr_data  output  DATA_W  output-buffer write data.
REQ-016 y, x  output  5 each  indices of the next word to be accepted.
REQ-017 ch  output  6  channel index of the next word to be accepted.
REQ-018 busy  output  1  high in RUN and FLUSH.
REQ-019 done  output  1  one-cycle pulse when the final word has been written.

Function
REQ-020 FSM states: IDLE, RUN, FLUSH, DONE; the reset state is IDLE.
REQ-021 IDLE: in_ready=0; on start, clear y, x, ch and the address counter, then go to RUN.
REQ-022 A transfer occurs when in_valid && in_ready; there is no transfer in any other case.
REQ-023 A write retires when wr_en && mem_ready.
REQ-024 RUN: in_ready = !wr_en || mem_ready (single-entry output register; no word is lost or duplicated).
REQ-025 On a transfer: wr_en<=1, wr_data<=in_data, wr_addr<=address counter; the address counter increments by 1.
REQ-026 If a write retires with no transfer in the same cycle, wr_en<=0; if a write retires with a transfer in the same cycle, wr_en stays 1 with the new word.
REQ-027 If wr_en && !mem_ready: wr_en, wr_addr and wr_data hold, and in_ready=0.
REQ-028 Index advance on each transfer:
- y increments;
- at y==Y_MAX, y wraps to 0 and x increments;
- at x==X_MAX with the y wrap, x wraps to 0 and ch increments.
REQ-029 The address counter always equals (ch*(X_MAX+1)+x)*(Y_MAX+1)+y; it is implemented incrementally, with no multiplier.
REQ-030 A transfer at y==Y_MAX, x==X_MAX, ch==CH_MAX moves the state to FLUSH; in FLUSH, in_ready=0.
REQ-031 FLUSH: when the pending write retires, go to DONE; DONE asserts done for one cycle, then returns to IDLE.
REQ-032 start asserted outside IDLE is ignored.
REQ-033 in_valid asserted in IDLE, FLUSH or DONE is not consumed; in_data is don't-care.

Reset
REQ-034 On rst low, immediately and regardless of clk:
- state = IDLE;
- y, x, ch, address counter, wr_addr and wr_data = 0;
- wr_en, in_ready, busy and done = 0.
REQ-035 Reset asserted mid-frame discards the pending write; no write is issued after rst rises until a new start.

Verification
REQ-036 start; in_valid=1 and mem_ready=1 continuously -> 57600 writes at addresses 0..57599 in order, in_data order preserved, done 1 cycle after the last retire.
REQ-037 After 29 transfers (y=29, x=0) -> the next transfer is written at address 29, and the indices become y=0, x=1.
REQ-038 After 899 transfers -> the next transfer is written at address 899 and the indices become y=0, x=0, ch=1.
REQ-039 mem_ready=0 for 5 cycles with a word pending -> wr_* held stable, in_ready=0, no transfer; resume with no gap and no duplicate.
REQ-040 Random in_valid/mem_ready over a reduced frame (Y_MAX=2, X_MAX=1, CH_MAX=1) -> 12 writes, addresses 0..11, scoreboard match.
REQ-041 rst pulsed low mid-frame, then start -> wr_en drops at once and addresses restart at 0; start pulsed during RUN -> no effect.

Source files
------------

// File: rtl/ofmap_writer_layer_3.sv
// Output-feature-map writer: accepts PE results in (ch, x, y) loop order and
// streams them to the output buffer through a single-entry write register.
module ofmap_writer_layer_3 #(
  parameter int DATA_W = 16,
  parameter int Y_MAX  = 29,
  parameter int X_MAX  = 29,
  parameter int CH_MAX = 63,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              mem_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [4:0]        y,
  output logic [4:0]        x,
  output logic [5:0]        ch,
  output logic              busy,
  output logic              done
);

  localparam logic [4:0] Y_LAST  = 5'(Y_MAX);
  localparam logic [4:0] X_LAST  = 5'(X_MAX);
  localparam logic [5:0] CH_LAST = 6'(CH_MAX);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_cnt;
  logic              xfer;
  logic              retire;
  logic              y_last, x_last, ch_last;

  assign xfer    = in_valid && in_ready;
  assign retire  = wr_en && mem_ready;
  assign y_last  = (y == Y_LAST);
  assign x_last  = (x == X_LAST);
  assign ch_last = (ch == CH_LAST);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy     = 1'b1;
        // The output register can take a new word when empty or draining now.
        in_ready = !wr_en || mem_ready;
        if (in_valid && in_ready && y_last && x_last && ch_last)
          state_nxt = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (retire) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Index/address stage: the linear address simply counts transfers because
  // y is the innermost loop, so no multiplier is needed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y        <= '0;
      x        <= '0;
      ch       <= '0;
      addr_cnt <= '0;
    end else if (state == IDLE && start) begin
      y        <= '0;
      x        <= '0;
      ch       <= '0;
      addr_cnt <= '0;
    end else if (xfer) begin
      addr_cnt <= addr_cnt + ADDR_W'(1);
      if (y_last) begin
        y <= '0;
        if (x_last) begin
          x  <= '0;
          ch <= ch_last ? 6'd0 : ch + 6'd1;
        end else begin
          x <= x + 5'd1;
        end
      end else begin
        y <= y + 5'd1;
      end
    end
  end

  // Write register stage: a transfer always refills it, even while draining.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (xfer) begin
      wr_en   <= 1'b1;
      wr_addr <= addr_cnt;
      wr_data <= in_data;
    end else if (retire) begin
      wr_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ofmap_writer_layer_3.sv
// Directed bench for ofmap_writer_layer_3: full default frame with stalls and
// index boundaries, reset/start behaviour, and a reduced frame with random flow.
module tb_ofmap_writer_layer_3;

  localparam int TOTAL   = 57600;
  localparam int B_TOTAL = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start, in_valid, mem_ready, in_ready, wr_en, busy, done;
  logic [15:0] in_data, wr_data, wr_addr;
  logic [4:0]  y, x;
  logic [5:0]  ch;

  logic        start_b, in_valid_b, mem_ready_b, in_ready_b, wr_en_b, busy_b, done_b;
  logic [15:0] in_data_b, wr_data_b, wr_addr_b;
  logic [4:0]  y_b, x_b;
  logic [5:0]  ch_b;

  int n_tests = 0;
  int n_fail  = 0;

  ofmap_writer_layer_3 dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_ready(mem_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .y(y), .x(x), .ch(ch), .busy(busy), .done(done)
  );

  ofmap_writer_layer_3 #(.Y_MAX(2), .X_MAX(1), .CH_MAX(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid_b), .in_data(in_data_b),
    .in_ready(in_ready_b), .mem_ready(mem_ready_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
    .wr_data(wr_data_b), .y(y_b), .x(x_b), .ch(ch_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int k);
    return 16'(k) ^ 16'hA5C3;
  endfunction

  initial begin
    int  xfer, ret, cyc, aerr, derr, stall_n, flush_n, idle_err, seen;
    bit  stl, fst;

    rst = 1'b0; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b0; in_data = '0;
    start_b = 1'b0; in_valid_b = 1'b0; mem_ready_b = 1'b0; in_data_b = '0;
    #12;
    check("rst_wr_en",    32'(wr_en),    32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_wr_addr",  32'(wr_addr),  32'd0);
    check("rst_wr_data",  32'(wr_data),  32'd0);
    check("rst_y",        32'(y),        32'd0);
    check("rst_x",        32'(x),        32'd0);
    check("rst_ch",       32'(ch),       32'd0);

    @(negedge clk); rst = 1'b1;
    in_valid = 1'b1; mem_ready = 1'b1;
    @(negedge clk); #1;
    check("idle_ignores_valid", 32'(in_ready), 32'd0);
    in_valid = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    check("run_busy",     32'(busy),     32'd1);
    check("run_in_ready", 32'(in_ready), 32'd1);

    // Full frame, continuous flow apart from a 5-cycle stall and a flush stall.
    xfer = 0; ret = 0; cyc = 0; aerr = 0; derr = 0; stall_n = 0; flush_n = 0;
    while (ret < TOTAL && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      stl = (xfer == 100 && stall_n < 5);
      fst = (xfer == TOTAL && flush_n < 2);
      mem_ready = !(stl || fst);
      in_valid  = 1'b1;
      in_data   = pat(xfer);
      #1;
      if (stl) begin
        check("stall_wr_en",    32'(wr_en),    32'd1);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_wr_addr",  32'(wr_addr),  32'd99);
        check("stall_wr_data",  32'(wr_data),  32'(pat(99)));
        stall_n++;
      end
      if (fst) begin
        check("flush_in_ready", 32'(in_ready), 32'd0);
        check("flush_busy",     32'(busy),     32'd1);
        check("flush_done",     32'(done),     32'd0);
        check("flush_wr_addr",  32'(wr_addr),  32'(TOTAL - 1));
        flush_n++;
      end
      if (xfer == 29) begin
        check("i29_y", 32'(y), 32'd29);
        check("i29_x", 32'(x), 32'd0);
      end
      if (xfer == 30) begin
        check("i30_y",    32'(y),       32'd0);
        check("i30_x",    32'(x),       32'd1);
        check("i30_addr", 32'(wr_addr), 32'd29);
      end
      if (xfer == 899) begin
        check("i899_y",  32'(y),  32'd29);
        check("i899_x",  32'(x),  32'd29);
        check("i899_ch", 32'(ch), 32'd0);
      end
      if (xfer == 900) begin
        check("i900_y",    32'(y),       32'd0);
        check("i900_x",    32'(x),       32'd0);
        check("i900_ch",   32'(ch),      32'd1);
        check("i900_addr", 32'(wr_addr), 32'd899);
        check("i900_data", 32'(wr_data), 32'(pat(899)));
      end
      if (wr_en && mem_ready) begin
        if (wr_addr != 16'(ret)) aerr++;
        if (wr_data != pat(ret)) derr++;
        ret++;
      end
      if (in_valid && in_ready) xfer++;
    end
    check("frame_writes",    32'(ret),  32'(TOTAL));
    check("frame_transfers", 32'(xfer), 32'(TOTAL));
    check("frame_addr_errs", 32'(aerr), 32'd0);
    check("frame_data_errs", 32'(derr), 32'd0);

    @(negedge clk); #1;
    check("done_pulse",   32'(done),  32'd1);
    check("done_busy",    32'(busy),  32'd0);
    check("done_wr_en",   32'(wr_en), 32'd0);
    @(negedge clk); #1;
    check("done_cleared", 32'(done),     32'd0);
    check("idle_ready",   32'(in_ready), 32'd0);

    // Start during RUN must not restart; async reset must kill the pending write.
    in_valid = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0; in_valid = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = pat(i);
      @(negedge clk);
    end
    in_data = pat(10); start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    check("run_start_y",    32'(y),       32'd11);
    check("run_start_addr", 32'(wr_addr), 32'd10);
    check("run_start_data", 32'(wr_data), 32'(pat(10)));
    #1 rst = 1'b0;
    #1;
    check("arst_wr_en",    32'(wr_en),    32'd0);
    check("arst_busy",     32'(busy),     32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    check("arst_wr_addr",  32'(wr_addr),  32'd0);
    check("arst_y",        32'(y),        32'd0);
    @(negedge clk); rst = 1'b1;
    idle_err = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (wr_en || in_ready) idle_err++;
    end
    check("post_rst_no_write", 32'(idle_err), 32'd0);
    start = 1'b1;
    @(negedge clk); start = 1'b0; in_data = pat(77);
    @(negedge clk); #1;
    check("restart_wr_en", 32'(wr_en),   32'd1);
    check("restart_addr",  32'(wr_addr), 32'd0);
    check("restart_data",  32'(wr_data), 32'(pat(77)));
    in_valid = 1'b0;

    // Reduced frame with random valid/ready.
    start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    xfer = 0; ret = 0; cyc = 0; aerr = 0; derr = 0; seen = 0;
    while (seen == 0 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      in_valid_b  = 1'($urandom_range(0, 1));
      mem_ready_b = 1'($urandom_range(0, 1));
      in_data_b   = pat(xfer + 300);
      #1;
      if (done_b) begin
        seen = 1;
        check("b_done_after_all", 32'(ret), 32'(B_TOTAL));
      end
      if (wr_en_b && mem_ready_b) begin
        if (wr_addr_b != 16'(ret)) aerr++;
        if (wr_data_b != pat(ret + 300)) derr++;
        ret++;
      end
      if (in_valid_b && in_ready_b) xfer++;
    end
    check("b_done_seen", 32'(seen), 32'd1);
    check("b_writes",    32'(ret),  32'(B_TOTAL));
    check("b_transfers", 32'(xfer), 32'(B_TOTAL));
    check("b_addr_errs", 32'(aerr), 32'd0);
    check("b_data_errs", 32'(derr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
